regfile_dump_reader: RTL and testbench

//  Debug/snapshot reader for the processor's 32x32 register file: on a start pulse it

---
 rtl/regfile_dump_reader.sv | 141 ++++++++++++++
 tb/tb_regfile_dump_reader.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump_reader.sv
// Register file dump reader: walks an index range over one combinational read port
// and streams each word out on a valid/ready channel, with busy/done status.
module regfile_dump_reader #(
    parameter int ADDR_W    = 5,
    parameter int DATA_W    = 32,
    parameter int SKIP_ZERO = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W-1:0] last_addr,
    output logic [ADDR_W-1:0] rf_addr,
    input  logic [DATA_W-1:0] rf_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   cur_q;
    logic [ADDR_W-1:0]   last_q;
    logic                out_valid_q;
    logic [DATA_W-1:0]   out_data_q;
    logic [ADDR_W-1:0]   out_addr_q;
    logic                out_last_q;
    logic                busy_q;
    logic                done_q;

    logic                skip_w;
    logic [ADDR_W-1:0]   inc_d;
    logic [ADDR_W-1:0]   start_cur_d;
    logic                final_w;
    logic                empty_w;

    assign skip_w = (SKIP_ZERO != 0);

    always_comb begin
        inc_d = cur_q + ADDR_W'(1);
        if (skip_w && inc_d == '0) begin
            inc_d = ADDR_W'(1);
        end
    end

    // With the zero register skipped, a range starting at 0 really starts at 1,
    // unless the range is {0} alone, which yields no beats at all.
    assign start_cur_d = (skip_w && first_addr == '0 && last_addr != '0) ? ADDR_W'(1) : first_addr;

    // A skipped last index of 0 means the walk ends at the top index instead.
    assign final_w = (cur_q == last_q) || (skip_w && last_q == '0 && cur_q == '1);
    assign empty_w = skip_w && cur_q == '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cur_q       <= '0;
            last_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start && !abort) begin
                        last_q  <= last_addr;
                        cur_q   <= start_cur_d;
                        busy_q  <= 1'b1;
                        state_q <= READ;
                    end
                end
                READ: begin
                    if (abort) begin
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                        busy_q      <= 1'b0;
                        cur_q       <= '0;
                        state_q     <= IDLE;
                    end else if (empty_w) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        cur_q   <= '0;
                        state_q <= IDLE;
                    end else begin
                        out_data_q  <= rf_data;
                        out_addr_q  <= cur_q;
                        out_last_q  <= final_w;
                        out_valid_q <= 1'b1;
                        state_q     <= HOLD;
                    end
                end
                HOLD: begin
                    if (abort) begin
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                        busy_q      <= 1'b0;
                        cur_q       <= '0;
                        state_q     <= IDLE;
                    end else if (out_valid_q && out_ready) begin
                        out_valid_q <= 1'b0;
                        if (out_last_q) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            cur_q   <= '0;
                            state_q <= IDLE;
                        end else begin
                            cur_q   <= inc_d;
                            state_q <= READ;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign rf_addr   = cur_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_addr  = out_addr_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader: one instance with SKIP_ZERO=0, one with
// SKIP_ZERO=1, each reading a modelled register file.
module tb_regfile_dump_reader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start [2];
    logic        abort [2];
    logic        ready [2];
    logic [4:0]  first_a [2];
    logic [4:0]  last_a [2];
    logic [4:0]  rf_addr [2];
    logic [31:0] rf_data [2];
    logic        out_valid [2];
    logic [31:0] out_data [2];
    logic [4:0]  out_addr [2];
    logic        out_last [2];
    logic        busy [2];
    logic        done [2];
    logic [31:0] rf [32];

    int n_chk  = 0;
    int n_pass = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    assign rf_data[0] = rf[rf_addr[0]];
    assign rf_data[1] = rf[rf_addr[1]];

    regfile_dump_reader #(.ADDR_W(5), .DATA_W(32), .SKIP_ZERO(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .abort(abort[0]),
        .first_addr(first_a[0]), .last_addr(last_a[0]), .rf_addr(rf_addr[0]),
        .rf_data(rf_data[0]), .out_valid(out_valid[0]), .out_ready(ready[0]),
        .out_data(out_data[0]), .out_addr(out_addr[0]), .out_last(out_last[0]),
        .busy(busy[0]), .done(done[0])
    );

    regfile_dump_reader #(.ADDR_W(5), .DATA_W(32), .SKIP_ZERO(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .abort(abort[1]),
        .first_addr(first_a[1]), .last_addr(last_a[1]), .rf_addr(rf_addr[1]),
        .rf_data(rf_data[1]), .out_valid(out_valid[1]), .out_ready(ready[1]),
        .out_data(out_data[1]), .out_addr(out_addr[1]), .out_last(out_last[1]),
        .busy(busy[1]), .done(done[1])
    );

    function automatic logic [31:0] exp_data(input int a);
        case (a)
            3:       return 32'h0000_000A;
            4:       return 32'h0000_000B;
            5:       return 32'h0000_000C;
            default: return 32'hC0DE_0000 + 32'(a);
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Starts a dump on instance z and checks each beat against exp_q; ready is held
    // low for stall_n cycles the first time the beat from stall_addr is presented.
    task automatic run_dump(input int z, input logic [4:0] f, input logic [4:0] l,
                            input int stall_addr, input int stall_n);
        int idx   = 0;
        int stall = stall_n;
        bit fin   = 0;
        first_a[z] = f;
        last_a[z]  = l;
        start[z]   = 1'b1;
        ready[z]   = 1'b1;
        @(negedge clk);
        start[z] = 1'b0;
        chk($sformatf("busy_after_start[%0d]", z), 32'(busy[z]), 1);
        chk($sformatf("no_valid_in_read[%0d]", z), 32'(out_valid[z]), 0);
        chk($sformatf("no_early_done[%0d]", z), 32'(done[z]), 0);
        @(negedge clk);
        for (int c = 0; c < 200 && !fin; c++) begin
            if (out_valid[z]) begin
                if (idx >= exp_q.size()) begin
                    chk($sformatf("beat_count_overrun[%0d]", z), 32'(idx + 1), 32'(exp_q.size()));
                    fin = 1;
                end else begin
                    chk($sformatf("addr[%0d] beat %0d", z, idx), 32'(out_addr[z]), 32'(exp_q[idx]));
                    chk($sformatf("data[%0d] beat %0d", z, idx), out_data[z], exp_data(exp_q[idx]));
                    chk($sformatf("last[%0d] beat %0d", z, idx), 32'(out_last[z]),
                        32'(idx == exp_q.size() - 1));
                    chk($sformatf("rf_addr[%0d] beat %0d", z, idx), 32'(rf_addr[z]), 32'(exp_q[idx]));
                    chk($sformatf("done_with_valid[%0d]", z), 32'(done[z]), 0);
                    if (stall > 0 && exp_q[idx] == stall_addr) begin
                        ready[z] = 1'b0;
                        stall--;
                    end else begin
                        ready[z] = 1'b1;
                        idx++;
                    end
                end
            end else if (done[z]) begin
                chk($sformatf("busy_low_at_done[%0d]", z), 32'(busy[z]), 0);
                chk($sformatf("rf_addr_idle[%0d]", z), 32'(rf_addr[z]), 0);
                fin = 1;
            end
            if (!fin) @(negedge clk);
        end
        chk($sformatf("dump_finished[%0d]", z), 32'(fin), 1);
        chk($sformatf("beat_count[%0d]", z), 32'(idx), 32'(exp_q.size()));
        @(negedge clk);
        chk($sformatf("done_one_cycle[%0d]", z), 32'(done[z]), 0);
        chk($sformatf("busy_after_done[%0d]", z), 32'(busy[z]), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = exp_data(i);
        for (int k = 0; k < 2; k++) begin
            start[k] = 1'b0; abort[k] = 1'b0; ready[k] = 1'b1;
            first_a[k] = '0; last_a[k] = '0;
        end

        #12;
        chk("reset_valid", 32'(out_valid[0]), 0);
        chk("reset_busy", 32'(busy[0]), 0);
        chk("reset_done", 32'(done[0]), 0);
        chk("reset_rf_addr", 32'(rf_addr[0]), 0);
        chk("reset_out_data", out_data[0], 0);
        chk("reset_out_addr", 32'(out_addr[0]), 0);
        chk("reset_out_last", 32'(out_last[0]), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        exp_q = '{3, 4, 5};
        run_dump(0, 5'd3, 5'd5, -1, 0);
        exp_q = '{30, 31, 0, 1};
        run_dump(0, 5'd30, 5'd1, -1, 0);
        exp_q = '{7};
        run_dump(0, 5'd7, 5'd7, -1, 0);
        exp_q = '{31, 1, 2};
        run_dump(1, 5'd31, 5'd2, -1, 0);
        exp_q.delete();
        run_dump(1, 5'd0, 5'd0, -1, 0);
        exp_q = '{1, 2, 3};
        run_dump(1, 5'd0, 5'd3, -1, 0);
        exp_q = '{2, 3, 4, 5, 6};
        run_dump(0, 5'd2, 5'd6, 4, 5);

        // abort together with an accepting ready: beat dropped, no done
        first_a[0] = 5'd3; last_a[0] = 5'd5; start[0] = 1'b1; ready[0] = 1'b0;
        @(negedge clk);
        start[0] = 1'b0;
        @(negedge clk);
        chk("abort_pre_valid", 32'(out_valid[0]), 1);
        chk("abort_pre_addr", 32'(out_addr[0]), 3);
        ready[0] = 1'b1; abort[0] = 1'b1;
        @(negedge clk);
        abort[0] = 1'b0;
        chk("abort_valid", 32'(out_valid[0]), 0);
        chk("abort_last", 32'(out_last[0]), 0);
        chk("abort_busy", 32'(busy[0]), 0);
        chk("abort_done", 32'(done[0]), 0);
        chk("abort_rf_addr", 32'(rf_addr[0]), 0);
        exp_q = '{8, 9};
        run_dump(0, 5'd8, 5'd9, -1, 0);

        // start held during busy is ignored, then async reset mid-dump
        first_a[0] = 5'd3; last_a[0] = 5'd5; start[0] = 1'b1; ready[0] = 1'b0;
        @(negedge clk);
        first_a[0] = 5'd20; last_a[0] = 5'd21;
        @(negedge clk);
        chk("ign_start_valid", 32'(out_valid[0]), 1);
        chk("ign_start_addr", 32'(out_addr[0]), 3);
        @(negedge clk);
        start[0] = 1'b0;
        chk("ign_start_hold_addr", 32'(out_addr[0]), 3);
        chk("ign_start_hold_data", out_data[0], 32'h0000_000A);
        chk("ign_start_busy", 32'(busy[0]), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", 32'(out_valid[0]), 0);
        chk("rst_mid_busy", 32'(busy[0]), 0);
        chk("rst_mid_rf_addr", 32'(rf_addr[0]), 0);
        chk("rst_mid_out_addr", 32'(out_addr[0]), 0);
        chk("rst_mid_out_data", out_data[0], 0);
        chk("rst_mid_out_last", 32'(out_last[0]), 0);
        @(negedge clk);
        rst_n = 1'b1;
        ready[0] = 1'b1;
        @(negedge clk);
        chk("rst_mid_no_done", 32'(done[0]), 0);
        chk("rst_mid_stays_idle", 32'(busy[0]), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
